// File: rtl/instruction_fetch.sv
// Fetch stage: PC register driving instruction memory plus a 2-entry
// {pc, word} queue handed to decode over a valid/ready handshake.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   output logic [31:0] DIR,
   input  logic [31:0] DO,
   input  logic        BR_TAKEN,
   input  logic [31:0] BR_TARGET,
   output logic        INST_VALID,
   input  logic        INST_READY,
   output logic [31:0] INST,
   output logic [31:0] INST_PC
);

   logic [31:0] pc;
   logic [31:0] slotPc   [2];
   logic [31:0] slotWord [2];
   logic        rdPtr;
   logic        wrPtr;
   logic [1:0]  count;
   logic        pop;
   logic        push;

   assign DIR        = pc;
   assign INST_VALID = (count != 2'd0);
   assign INST       = slotWord[rdPtr];
   assign INST_PC    = slotPc[rdPtr];

   // A full queue can still accept a word when the head leaves on the same edge.
   assign pop  = INST_VALID & INST_READY;
   assign push = ~BR_TAKEN & ((count != 2'd2) | pop);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pc          <= RESET_PC;
         rdPtr       <= 1'b0;
         wrPtr       <= 1'b0;
         count       <= 2'd0;
         slotPc[0]   <= 32'd0;
         slotPc[1]   <= 32'd0;
         slotWord[0] <= 32'd0;
         slotWord[1] <= 32'd0;
      end else if (BR_TAKEN) begin
         pc    <= {BR_TARGET[31:2], 2'b00};
         rdPtr <= 1'b0;
         wrPtr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            slotPc[wrPtr]   <= pc;
            slotWord[wrPtr] <= DO;
            pc              <= pc + 32'd4;
            wrPtr           <= ~wrPtr;
         end
         if (pop) begin
            rdPtr <= ~rdPtr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed test-plan steps followed
// by random traffic, all compared against a queue-based reference model.
module tb_instruction_fetch;

   logic        CLK;
   logic        RST_N;
   logic [31:0] DIR;
   logic [31:0] DO;
   logic        BR_TAKEN;
   logic [31:0] BR_TARGET;
   logic        INST_VALID;
   logic        INST_READY;
   logic [31:0] INST;
   logic [31:0] INST_PC;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } entry_t;

   entry_t      modelQ[$];
   logic [31:0] modelPc;
   int          vectors;
   int          miscompares;

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .DIR        (DIR),
      .DO         (DO),
      .BR_TAKEN   (BR_TAKEN),
      .BR_TARGET  (BR_TARGET),
      .INST_VALID (INST_VALID),
      .INST_READY (INST_READY),
      .INST       (INST),
      .INST_PC    (INST_PC)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Instruction memory: four preloaded words, a fixed scramble of the address elsewhere.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      case (addr)
         32'd0:   return 32'h0000_00FF;
         32'd4:   return 32'h0000_FF00;
         32'd8:   return 32'h00FF_0000;
         32'd12:  return 32'hFF00_0000;
         default: return addr ^ 32'h5A5A_C3C3;
      endcase
   endfunction

   assign DO = memWord(DIR);

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".dir"}, DIR, modelPc);
      checkValue({tag, ".valid"}, {31'd0, INST_VALID}, {31'd0, modelQ.size() != 0});
      if (modelQ.size() != 0) begin
         checkValue({tag, ".inst"}, INST, modelQ[0].word);
         checkValue({tag, ".pc"}, INST_PC, modelQ[0].pc);
      end
   endtask

   // Drive one cycle of inputs, advance the model by the stage's rules, then compare.
   task automatic applyStimulus(input logic rstn, input logic br, input logic [31:0] tgt,
                                input logic ready, input string tag);
      logic doPop;
      RST_N      = rstn;
      BR_TAKEN   = br;
      BR_TARGET  = tgt;
      INST_READY = ready;
      doPop = (modelQ.size() != 0) && ready;
      if (!rstn) begin
         modelQ.delete();
         modelPc = 32'h0000_0000;
      end else if (br) begin
         modelQ.delete();
         modelPc = tgt & 32'hFFFF_FFFC;
      end else begin
         if (doPop) void'(modelQ.pop_front());
         if (modelQ.size() < 2) begin
            modelQ.push_back('{pc: modelPc, word: memWord(modelPc)});
            modelPc = modelPc + 32'd4;
         end
      end
      @(posedge CLK);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      modelPc     = 32'd0;
      RST_N       = 1'b0;
      BR_TAKEN    = 1'b0;
      BR_TARGET   = 32'd0;
      INST_READY  = 1'b0;

      // Reset state and an unbroken stream from address 0
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, "reset0");
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, "reset1");
      checkValue("reset.inst", INST, 32'd0);
      checkValue("reset.instpc", INST_PC, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "stream0");
      checkValue("stream0.word", INST, 32'h0000_00FF);
      for (int i = 1; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "stream");
      checkValue("stream3.word", INST, 32'hFF00_0000);
      checkValue("stream3.pc", INST_PC, 32'd12);

      // Backpressure: queue fills and PC stalls at 8, then drains in order
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, "bpReset");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, "bpStall");
      checkValue("bp.dirHold", DIR, 32'd8);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "bpDrain");

      // Redirect with a full queue, misaligned target
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, "brReset");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, "brFill");
      applyStimulus(1'b1, 1'b1, 32'h0000_000E, 1'b0, "brTake");
      checkValue("br.dir", DIR, 32'd12);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "brTarget");
      checkValue("br.word", INST, 32'hFF00_0000);

      // Redirect on the same edge as a pop
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "popBrPre");
      applyStimulus(1'b1, 1'b1, 32'd4, 1'b1, "popBr");
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "popBrNext");
      checkValue("popBr.pc", INST_PC, 32'd4);

      // PC wraps past the top of the address space
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, "wrapBr");
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "wrap0");
      checkValue("wrap0.pc", INST_PC, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "wrap1");
      checkValue("wrap1.pc", INST_PC, 32'h0000_0000);

      // Reset beats a simultaneous redirect while full
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, "rstFill");
      applyStimulus(1'b0, 1'b1, 32'h0000_0020, 1'b0, "rstBr");
      checkValue("rstBr.inst", INST, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, "rstRestart");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 31) != 0, $urandom_range(0, 7) == 0,
                       $urandom, $urandom_range(0, 3) != 0, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
